// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target receiver: FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer for one I2C line; with I2C_TARGET_GLITCH_FILTER_EN defined the
// synchronized level must hold FILTER_LEN consecutive samples before the output follows it.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_Clk,
  input  logic reset_n,
  input  logic i_line,
  output logic o_level
);

  logic [1:0] sync_q;

  // Idle-high bus: synchronizers come out of reset at 1 so no false START appears.
  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], i_line};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) level_d = sync_q[1];
      else                              cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;
`else
  assign o_level = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver for master writes: START/STOP detect, 7-bit address match, ACK, byte hand-off.
// Optional input glitch filter selected by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR       = 7'h3C,
  parameter int         FILTER_LEN = 3
) (
  input  logic           i_Clk,
  input  logic           reset_n,
  input  logic           i_scl,
  input  logic           i_sda,
  output logic           o_sda_oe,
  output logic [7:0]     o_rx_data,
  output logic           o_rx_valid,
  input  logic           i_rx_ready,
  output logic           o_busy,
  output logic           o_nack_ovr,
  output i2c_tgt_state_t o_dbg_state
);

  // Byte port: o_rx_valid holds until a cycle with o_rx_valid && i_rx_ready, then clears next cycle.

  logic scl_lvl, sda_lvl;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .i_Clk   (i_Clk),
    .reset_n (reset_n),
    .i_line  (i_scl),
    .o_level (scl_lvl)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .i_Clk   (i_Clk),
    .reset_n (reset_n),
    .i_line  (i_sda),
    .o_level (sda_lvl)
  );

  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  assign scl_rise  =  scl_lvl & ~scl_prev_q;
  assign scl_fall  = ~scl_lvl &  scl_prev_q;
  assign start_det =  scl_lvl &  scl_prev_q &  sda_prev_q & ~sda_lvl;
  assign stop_det  =  scl_lvl &  scl_prev_q & ~sda_prev_q &  sda_lvl;

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic           nack_ovr_q, nack_ovr_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    nack_ovr_d = 1'b0;

    if (rx_valid_q && i_rx_ready) rx_valid_d = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // Covers both a fresh START and a repeated START; busy is left as is.
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == ADDR && shift_q[0] == I2C_RW_WRITE) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else if (!rx_valid_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = ST_DATA_ACK;
            end else begin
              // Consumer still holds the previous byte: refuse this one.
              nack_ovr_d = 1'b1;
              state_d    = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_ovr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      nack_ovr_q <= nack_ovr_d;
    end
  end

  assign o_sda_oe    = sda_oe_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_busy      = busy_q;
  assign o_nack_ovr  = nack_ovr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged I2C master with open-drain SDA wired against o_sda_oe.
module tb_i2c_target_rx;
  import i2c_pkg::*;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int GLITCH_BIT = 4;
`else
  localparam int GLITCH_BIT = -1;
`endif

  logic           clk;
  logic           reset_n;
  logic           scl_drv;
  logic           sda_drv;
  logic           sda_bus;
  logic           rx_ready;
  logic           o_sda_oe;
  logic [7:0]     o_rx_data;
  logic           o_rx_valid;
  logic           o_busy;
  logic           o_nack_ovr;
  i2c_tgt_state_t o_dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         nack_cnt = 0;
  int         oe_cnt   = 0;

  assign sda_bus = sda_drv & ~o_sda_oe;

  i2c_target_rx #(.ADDR(7'h3C), .FILTER_LEN(3)) dut (
    .i_Clk       (clk),
    .reset_n     (reset_n),
    .i_scl       (scl_drv),
    .i_sda       (sda_bus),
    .o_sda_oe    (o_sda_oe),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .i_rx_ready  (rx_ready),
    .o_busy      (o_busy),
    .o_nack_ovr  (o_nack_ovr),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation of the byte port and SDA drive, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_rx_valid && rx_ready) got_q.push_back(o_rx_data);
      if (o_nack_ovr) nack_cnt++;
      if (o_sda_oe) oe_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver tasks: quarter bit = 8 clocks
  task automatic bus_start();
    sda_drv = 1'b0; tick(8);
    scl_drv = 1'b0; tick(8);
  endtask

  task automatic bus_rstart();
    sda_drv = 1'b1; tick(8);
    scl_drv = 1'b1; tick(8);
    sda_drv = 1'b0; tick(8);
    scl_drv = 1'b0; tick(8);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(8);
    scl_drv = 1'b1; tick(8);
    sda_drv = 1'b1; tick(16);
  endtask

  task automatic bus_bit(input logic b, input bit glitch);
    sda_drv = b; tick(8);
    scl_drv = 1'b1; tick(8);
    if (glitch) begin
      scl_drv = 1'b0; tick(1);
      scl_drv = 1'b1;
    end
    tick(8);
    scl_drv = 1'b0; tick(8);
  endtask

  task automatic bus_ack(output logic acked);
    sda_drv = 1'b1; tick(8);
    scl_drv = 1'b1; tick(8);
    acked = (sda_bus === I2C_ACK);
    tick(8);
    scl_drv = 1'b0; tick(8);
  endtask

  task automatic bus_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], i == glitch_bit);
    bus_ack(acked);
  endtask

  task automatic clear_obs();
    exp_q.delete();
    got_q.delete();
    nack_cnt = 0;
    oe_cnt   = 0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    scl_drv  = 1'b1;
    sda_drv  = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    chk_cnt++; if (o_sda_oe !== 1'b0) $display("FAIL reset_sda_oe got=%b exp=0", o_sda_oe); else pass_cnt++;
    chk_cnt++; if (o_rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", o_rx_data); else pass_cnt++;
    chk_cnt++; if (o_rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", o_rx_valid); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else pass_cnt++;
    chk_cnt++; if (o_nack_ovr !== 1'b0) $display("FAIL reset_nack_ovr got=%b exp=0", o_nack_ovr); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, ST_IDLE); else pass_cnt++;
    reset_n = 1'b1;
    tick(8);
  endtask

  task automatic test_write_two_bytes();
    logic a0, a1, a2;
    clear_obs();
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    bus_start();
    bus_byte(8'h78, -1, a0);
    chk_cnt++; if (a0 !== 1'b1) $display("FAIL wr_addr_ack got=%b exp=1", a0); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b1) $display("FAIL wr_busy_after_addr got=%b exp=1", o_busy); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_DATA) $display("FAIL wr_state_data got=%0d exp=%0d", o_dbg_state, ST_DATA); else pass_cnt++;
    bus_byte(8'hA5, -1, a1);
    bus_byte(8'h5A, -1, a2);
    chk_cnt++; if (a1 !== 1'b1) $display("FAIL wr_byte0_ack got=%b exp=1", a1); else pass_cnt++;
    chk_cnt++; if (a2 !== 1'b1) $display("FAIL wr_byte1_ack got=%b exp=1", a2); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b1) $display("FAIL wr_busy_before_stop got=%b exp=1", o_busy); else pass_cnt++;
    bus_stop();
    chk_cnt++; if (o_busy !== 1'b0) $display("FAIL wr_busy_after_stop got=%b exp=0", o_busy); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_IDLE) $display("FAIL wr_state_idle got=%0d exp=%0d", o_dbg_state, ST_IDLE); else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL wr_byte_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        chk_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL wr_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    clear_obs();
    rx_ready = 1'b1;
    bus_start();
    bus_byte(8'h7A, -1, a0);
    chk_cnt++; if (a0 !== 1'b0) $display("FAIL wa_addr_nack got=%b exp=0", a0); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_IGNORE) $display("FAIL wa_state_ignore got=%0d exp=%0d", o_dbg_state, ST_IGNORE); else pass_cnt++;
    bus_byte(8'hA5, -1, a1);
    bus_stop();
    chk_cnt++; if (oe_cnt !== 0) $display("FAIL wa_sda_pulled got=%0d exp=0", oe_cnt); else pass_cnt++;
    chk_cnt++; if (got_q.size() !== 0) $display("FAIL wa_bytes got=%0d exp=0", got_q.size()); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_IDLE) $display("FAIL wa_state_idle got=%0d exp=%0d", o_dbg_state, ST_IDLE); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b0) $display("FAIL wa_busy got=%b exp=0", o_busy); else pass_cnt++;
  endtask

  task automatic test_read_nack();
    logic a0, a1;
    clear_obs();
    rx_ready = 1'b1;
    bus_start();
    bus_byte(8'h79, -1, a0);
    chk_cnt++; if (a0 !== 1'b0) $display("FAIL rd_nack got_ack=%b exp=0", a0); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_IGNORE) $display("FAIL rd_state_ignore got=%0d exp=%0d", o_dbg_state, ST_IGNORE); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b0) $display("FAIL rd_busy got=%b exp=0", o_busy); else pass_cnt++;
    bus_byte(8'h33, -1, a1);
    bus_stop();
    chk_cnt++; if (got_q.size() !== 0) $display("FAIL rd_bytes got=%0d exp=0", got_q.size()); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic a0, a1, a2;
    clear_obs();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    bus_start();
    bus_byte(8'h78, -1, a0);
    bus_byte(8'h11, -1, a1);
    bus_byte(8'h22, -1, a2);
    chk_cnt++; if (a1 !== 1'b1) $display("FAIL ovr_first_ack got=%b exp=1", a1); else pass_cnt++;
    chk_cnt++; if (a2 !== 1'b0) $display("FAIL ovr_second_nack got_ack=%b exp=0", a2); else pass_cnt++;
    chk_cnt++; if (nack_cnt !== 1) $display("FAIL ovr_pulse_count got=%0d exp=1", nack_cnt); else pass_cnt++;
    chk_cnt++; if (o_rx_data !== 8'h11) $display("FAIL ovr_data_held got=%h exp=11", o_rx_data); else pass_cnt++;
    chk_cnt++; if (o_rx_valid !== 1'b1) $display("FAIL ovr_valid_held got=%b exp=1", o_rx_valid); else pass_cnt++;
    chk_cnt++; if (o_dbg_state !== ST_IGNORE) $display("FAIL ovr_state_ignore got=%0d exp=%0d", o_dbg_state, ST_IGNORE); else pass_cnt++;
    bus_stop();
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    chk_cnt++; if (o_rx_valid !== 1'b0) $display("FAIL ovr_valid_cleared got=%b exp=0", o_rx_valid); else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) $display("FAIL ovr_consumed got_n=%0d exp_byte=%h", got_q.size(), exp_q[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_midbyte();
    clear_obs();
    rx_ready = 1'b1;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(((8'h78 >> i) & 8'h01) != 0, 1'b0);
    sda_drv = 1'b1;
    tick(8);
    chk_cnt++; if (o_sda_oe !== 1'b1) $display("FAIL rst_ack_driven got=%b exp=1", o_sda_oe); else pass_cnt++;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if (o_sda_oe !== 1'b0) $display("FAIL rst_async_release got=%b exp=0", o_sda_oe); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", o_busy); else pass_cnt++;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    chk_cnt++; if (o_dbg_state !== ST_IDLE) $display("FAIL rst_state_idle got=%0d exp=%0d", o_dbg_state, ST_IDLE); else pass_cnt++;
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    clear_obs();
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    bus_start();
    bus_byte(8'h78, -1, a0);
    bus_bit(1'b1, 1'b0);
    bus_bit(1'b0, 1'b0);
    bus_bit(1'b1, 1'b0);
    bus_bit(1'b0, 1'b0);
    bus_rstart();
    chk_cnt++; if (o_dbg_state !== ST_ADDR) $display("FAIL rs_state_addr got=%0d exp=%0d", o_dbg_state, ST_ADDR); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b1) $display("FAIL rs_busy_kept got=%b exp=1", o_busy); else pass_cnt++;
    bus_byte(8'h78, -1, a1);
    bus_byte(8'hC3, GLITCH_BIT, a2);
    chk_cnt++; if (a1 !== 1'b1) $display("FAIL rs_addr_ack got=%b exp=1", a1); else pass_cnt++;
    chk_cnt++; if (a2 !== 1'b1) $display("FAIL rs_byte_ack got=%b exp=1", a2); else pass_cnt++;
    bus_stop();
    chk_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) $display("FAIL rs_byte got_n=%0d exp_byte=%h", got_q.size(), exp_q[0]);
    else pass_cnt++;
    chk_cnt++; if (o_rx_data !== 8'hC3) $display("FAIL rs_rx_data got=%h exp=c3", o_rx_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_two_bytes();
    test_wrong_addr();
    test_read_nack();
    test_overrun();
    test_reset_midbyte();
    test_repeated_start();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
